// File: rtl/hazard_pkg.sv
// hazard_pkg: shared state encoding and constants for the hazard control unit
package hazard_pkg;

    typedef enum logic [1:0] {
        S_RUN,
        S_MEM_WAIT,
        S_ERROR
    } state_e;

    localparam logic [4:0] REG_X0          = 5'd0;
    localparam int         MEM_TIMEOUT_DEF = 64;

endpackage

// File: rtl/hazard_sat_counter.sv
// hazard_sat_counter: W-bit event counter that sticks at all-ones
module hazard_sat_counter #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] cnt_q, cnt_d;

    // advance on each event unless already saturated
    always_comb begin
        cnt_d = (i_inc && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    end

    // count register
    always_ff @(posedge i_clk) begin
        if (i_rst) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign o_cnt = cnt_q;

endmodule

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: load-use stall, redirect flush and data-memory wait freeze
// for a 5-stage pipeline; HAZARD_PERF_CNT_EN adds saturating event counters.
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int CNT_W       = 8,
    parameter int PERF_W      = 32
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [4:0] i_rs1_IFID,
    input  logic [4:0] i_rs2_IFID,
    input  logic       i_rs1_used_IFID,
    input  logic       i_rs2_used_IFID,
    input  logic [4:0] i_rd_IDEX,
    input  logic       i_clu_MemRead_IDEX,
    input  logic       i_branch_taken_EX,
    input  logic       i_dmem_valid_EXMEM,
    input  logic       i_dmem_ready,
    output logic       o_stall_PC,
    output logic       o_stall_IFID,
    output logic       o_bubble_IDEX,
    output logic       o_flush_IFID,
    output logic       o_flush_IDEX,
    output logic       o_freeze_back,
    output logic       o_mem_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] o_stall_cnt,
    output logic [PERF_W-1:0] o_flush_cnt,
    output logic [PERF_W-1:0] o_freeze_cnt
`endif
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;
    logic             freeze_raw, load_use_raw;
    logic             freeze, flush, load_use;

    // memory-wait FSM: enter on an unaccepted request, leave on ready, trap on watchdog expiry
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        case (state_q)
            S_RUN: begin
                if (i_dmem_valid_EXMEM && !i_dmem_ready) begin
                    state_d    = S_MEM_WAIT;
                    wait_cnt_d = CNT_W'(1);
                end
            end
            S_MEM_WAIT: begin
                if (i_dmem_ready) begin
                    state_d    = S_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
                    state_d   = S_ERROR;
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // FSM, watchdog and sticky error registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_RUN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // hazard detection in priority order: error/freeze, redirect flush, load-use
    always_comb begin
        freeze_raw   = (state_q == S_ERROR) ||
                       (state_q == S_MEM_WAIT && !i_dmem_ready) ||
                       (state_q == S_RUN && i_dmem_valid_EXMEM && !i_dmem_ready);
        load_use_raw = i_clu_MemRead_IDEX && (i_rd_IDEX != REG_X0) &&
                       ((i_rs1_used_IFID && i_rs1_IFID == i_rd_IDEX) ||
                        (i_rs2_used_IFID && i_rs2_IFID == i_rd_IDEX));
        freeze       = !i_rst && freeze_raw;
        flush        = !i_rst && !freeze_raw && i_branch_taken_EX;
        load_use     = !i_rst && !freeze_raw && !i_branch_taken_EX && load_use_raw;
    end

    assign o_stall_PC    = freeze || load_use;
    assign o_stall_IFID  = freeze || load_use;
    assign o_bubble_IDEX = load_use;
    assign o_flush_IFID  = flush;
    assign o_flush_IDEX  = flush;
    assign o_freeze_back = freeze;
    assign o_mem_timeout = timeout_q && !i_rst;

`ifdef HAZARD_PERF_CNT_EN
    hazard_sat_counter #(.W(PERF_W)) u_stall_cnt (
        .i_clk(i_clk), .i_rst(i_rst), .i_inc(load_use), .o_cnt(o_stall_cnt)
    );
    hazard_sat_counter #(.W(PERF_W)) u_flush_cnt (
        .i_clk(i_clk), .i_rst(i_rst), .i_inc(flush), .o_cnt(o_flush_cnt)
    );
    hazard_sat_counter #(.W(PERF_W)) u_freeze_cnt (
        .i_clk(i_clk), .i_rst(i_rst), .i_inc(freeze), .o_cnt(o_freeze_cnt)
    );
`else
    logic unused_perf_w;
    assign unused_perf_w = ^PERF_W;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: directed vectors with a queued expected-output scoreboard
module tb_hazard_control_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
    logic       u1 = 1'b0, u2 = 1'b0, mr = 1'b0, br = 1'b0, v = 1'b0, r = 1'b0;
    logic       stall_pc, stall_ifid, bubble, flush_ifid, flush_idex, freeze, tmo;
`ifdef HAZARD_PERF_CNT_EN
    logic [1:0] stall_cnt, flush_cnt, freeze_cnt;
`endif

    typedef struct {
        logic [6:0] v;
        int         id;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   vec_id = 0;

    always #5 clk = ~clk;

    hazard_control_unit #(.MEM_TIMEOUT(4), .CNT_W(8), .PERF_W(2)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_rs1_IFID(rs1), .i_rs2_IFID(rs2),
        .i_rs1_used_IFID(u1), .i_rs2_used_IFID(u2),
        .i_rd_IDEX(rd), .i_clu_MemRead_IDEX(mr),
        .i_branch_taken_EX(br),
        .i_dmem_valid_EXMEM(v), .i_dmem_ready(r),
        .o_stall_PC(stall_pc), .o_stall_IFID(stall_ifid), .o_bubble_IDEX(bubble),
        .o_flush_IFID(flush_ifid), .o_flush_IDEX(flush_idex),
        .o_freeze_back(freeze), .o_mem_timeout(tmo)
`ifdef HAZARD_PERF_CNT_EN
        , .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt), .o_freeze_cnt(freeze_cnt)
`endif
    );

    // expected bits: {stall_PC, stall_IFID, bubble, flush_IFID, flush_IDEX, freeze, timeout}
    task automatic step(input logic t_rst, input logic [4:0] t_rd, input logic t_mr,
                        input logic [4:0] t_rs1, input logic t_u1,
                        input logic [4:0] t_rs2, input logic t_u2,
                        input logic t_br, input logic t_v, input logic t_r,
                        input logic [6:0] t_exp);
        @(posedge clk);
        #1;
        rst = t_rst; rd = t_rd; mr = t_mr; rs1 = t_rs1; u1 = t_u1;
        rs2 = t_rs2; u2 = t_u2; br = t_br; v = t_v; r = t_r;
        q.push_back('{t_exp, vec_id});
        vec_id++;
    endtask

    task automatic check_cnt(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // monitor: compare the outputs of each issued cycle away from the clock edge
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t       e;
            logic [6:0] act;
            e   = q.pop_front();
            act = {stall_pc, stall_ifid, bubble, flush_ifid, flush_idex, freeze, tmo};
            checks++;
            if (act !== e.v) begin
                errors++;
                $display("FAIL vec%0d outputs: got %b expected %b", e.id, act, e.v);
            end
        end
    end

    initial begin
        //    rst rd mr rs1 u1 rs2 u2 br v  r  expected
        step(1, 5, 1, 5, 1, 0, 0, 1, 1, 0, 7'b0000000);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000);
        step(0, 5, 1, 5, 1, 0, 0, 0, 0, 0, 7'b1110000);
        step(0, 5, 0, 5, 1, 0, 0, 0, 0, 0, 7'b0000000);
        step(0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 7'b0000000);
        step(0, 7, 1, 3, 1, 7, 0, 0, 0, 0, 7'b0000000);
        step(0, 7, 1, 3, 1, 7, 1, 0, 0, 0, 7'b1110000);
        step(0, 7, 1, 3, 1, 7, 1, 1, 0, 0, 7'b0001100);
        step(0, 7, 1, 3, 1, 7, 1, 1, 1, 0, 7'b1100010);
        step(0, 7, 1, 3, 1, 7, 1, 1, 1, 0, 7'b1100010);
        step(0, 7, 1, 3, 1, 7, 1, 1, 1, 0, 7'b1100010);
        step(0, 7, 1, 3, 1, 7, 1, 1, 1, 1, 7'b0001100);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 7'b0000000);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7'b1100010);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7'b1100010);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7'b1100010);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7'b1100010);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1100011);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 7'b1100011);
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 7'b0000000);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000);
        step(0, 9, 1, 0, 0, 9, 1, 0, 0, 0, 7'b1110000);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7'b1100010);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7'b0000000);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000);
        step(0, 5, 1, 5, 1, 0, 0, 0, 0, 0, 7'b1110000);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000);
        step(0, 6, 1, 0, 0, 6, 1, 0, 0, 0, 7'b1110000);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 7'b0001100);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7'b1100010);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7'b1100010);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7'b1100010);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 7'b0000000);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000);
`ifdef HAZARD_PERF_CNT_EN
        @(negedge clk);
        check_cnt("stall_cnt", stall_cnt, 2'd2);
        check_cnt("flush_cnt", flush_cnt, 2'd1);
        check_cnt("freeze_cnt", freeze_cnt, 2'd3);
`endif
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7'b1100010);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 7'b0000000);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000);
`ifdef HAZARD_PERF_CNT_EN
        @(negedge clk);
        check_cnt("freeze_cnt_sat", freeze_cnt, 2'd3);
`endif
        for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
